// File: rtl/multicycle_proc_if.sv
// ----------------------------------------------------------------------------
// multicycle_proc_if
// Unified memory port shared by instruction fetch and data access.
//   mem_req   : request, held until mem_ack
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : byte address
//   mem_wdata : store data
//   mem_rdata : read data (instruction word on [31:0])
//   mem_ack   : request completes in this cycle
// Modports: master = processor side, slave = memory side.
// ----------------------------------------------------------------------------
interface multicycle_proc_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/multicycle_proc.sv
// ----------------------------------------------------------------------------
// multicycle_proc
// Multi-cycle LEGv8-subset core (LDUR, STUR, ADD, SUB, AND, ORR, CBZ, B).
// Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB] over one
// shared req/ack memory port. Illegal opcodes park the core in HALT.
// Ports:
//   CLK       : clock, rising edge
//   Reset     : synchronous, active-high
//   startPC   : PC loaded while Reset is high
//   currentPC : address of the instruction in progress
//   mem       : unified memory port (multicycle_proc_if.master)
//   retire    : one-cycle pulse per completed instruction
//   trap      : sticky, illegal opcode seen
// Optional macro MULTICYCLE_PERF_CNT_EN adds cycle_cnt / instr_cnt outputs.
// ----------------------------------------------------------------------------
module multicycle_proc #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] startPC,
   output logic [ADDR_W-1:0] currentPC,
   multicycle_proc_if.master mem,
   output logic              retire,
   output logic              trap
`ifdef MULTICYCLE_PERF_CNT_EN
   ,
   output logic [31:0]       cycle_cnt,
   output logic [31:0]       instr_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q, addr_q;
   logic              req_q, we_q, retire_q, trap_q;
   logic [DATA_W-1:0] wdata_q, a_q, b_q, res_q;
   logic [31:0]       ir_q;
   logic [DATA_W-1:0] rf_q [32];

   logic              is_ldur, is_stur, is_add, is_sub, is_and, is_orr, is_cbz, is_b;
   logic              legal_d, ack_d, retire_d;
   logic [4:0]        rn_d, rm_d, rt_d, rb_d;
   logic [DATA_W-1:0] a_rd_d, b_rd_d, alu_d;
   logic [ADDR_W-1:0] imm9_d, imm19_d, imm26_d, ls_addr_d, next_pc_d;
   logic              unused_shamt;

   always_comb begin
      is_ldur = (ir_q[31:21] == 11'h7C2);
      is_stur = (ir_q[31:21] == 11'h7C0);
      is_add  = (ir_q[31:21] == 11'h458);
      is_sub  = (ir_q[31:21] == 11'h658);
      is_and  = (ir_q[31:21] == 11'h450);
      is_orr  = (ir_q[31:21] == 11'h550);
      is_cbz  = (ir_q[31:24] == 8'hB4);
      is_b    = (ir_q[31:26] == 6'h05);
      legal_d = is_ldur | is_stur | is_add | is_sub | is_and | is_orr | is_cbz | is_b;
      rn_d    = ir_q[9:5];
      rm_d    = ir_q[20:16];
      rt_d    = ir_q[4:0];
      // STUR and CBZ take their second operand from Rt rather than Rm
      rb_d    = (is_stur | is_cbz) ? rt_d : rm_d;
      a_rd_d  = (rn_d == 5'd31) ? '0 : rf_q[rn_d];
      b_rd_d  = (rb_d == 5'd31) ? '0 : rf_q[rb_d];
   end

   assign unused_shamt = ^ir_q[11:10];

   assign imm9_d    = ADDR_W'($signed(ir_q[20:12]));
   assign imm19_d   = ADDR_W'($signed({ir_q[23:5], 2'b00}));
   assign imm26_d   = ADDR_W'($signed({ir_q[25:0], 2'b00}));
   assign ls_addr_d = ADDR_W'(a_q) + imm9_d;
   assign ack_d     = req_q & mem.mem_ack;

   always_comb begin
      alu_d = a_q + b_q;
      if (is_sub)      alu_d = a_q - b_q;
      else if (is_and) alu_d = a_q & b_q;
      else if (is_orr) alu_d = a_q | b_q;
   end

   always_comb begin
      next_pc_d = pc_q + ADDR_W'(4);
      if (state_q == S_EXEC) begin
         if (is_b)                       next_pc_d = pc_q + imm26_d;
         else if (is_cbz && b_q == '0)   next_pc_d = pc_q + imm19_d;
      end
   end

   assign retire_d = ((state_q == S_EXEC) && (is_b || is_cbz)) ||
                     ((state_q == S_MEM) && ack_d && we_q) ||
                     (state_q == S_WB);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q  <= S_FETCH;
         pc_q     <= startPC;
         addr_q   <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         retire_q <= 1'b0;
         trap_q   <= 1'b0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         retire_q <= 1'b0;
         case (state_q)
            S_FETCH: begin
               // Only reached with req low right after reset; every later
               // fetch is launched by the retiring instruction below.
               if (!req_q) begin
                  req_q  <= 1'b1;
                  we_q   <= 1'b0;
                  addr_q <= pc_q;
               end else if (ack_d) begin
                  req_q   <= 1'b0;
                  ir_q    <= mem.mem_rdata[31:0];
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!legal_d) begin
                  trap_q  <= 1'b1;
                  state_q <= S_HALT;
               end else begin
                  a_q     <= a_rd_d;
                  b_q     <= b_rd_d;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_ldur || is_stur) begin
                  req_q   <= 1'b1;
                  we_q    <= is_stur;
                  addr_q  <= ls_addr_d;
                  wdata_q <= b_q;
                  state_q <= S_MEM;
               end else if (!(is_b || is_cbz)) begin
                  res_q   <= alu_d;
                  state_q <= S_WB;
               end
            end
            S_MEM: begin
               if (ack_d) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  res_q   <= mem.mem_rdata;
                  state_q <= S_WB;
               end
            end
            S_WB: begin
               if (rt_d != 5'd31) rf_q[rt_d] <= res_q;
            end
            S_HALT: ;
            default: state_q <= S_HALT;
         endcase

         // Retirement overrides the per-state assignments above: it commits
         // the new PC and launches the next fetch in the same edge, so a
         // zero-wait fetch completes in the first FETCH cycle.
         if (retire_d) begin
            pc_q     <= next_pc_d;
            addr_q   <= next_pc_d;
            req_q    <= 1'b1;
            we_q     <= 1'b0;
            retire_q <= 1'b1;
            state_q  <= S_FETCH;
         end
      end
   end

   assign currentPC     = pc_q;
   assign retire        = retire_q;
   assign trap          = trap_q;
   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

`ifdef MULTICYCLE_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, instr_cnt_q;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (retire_d) instr_cnt_q <= instr_cnt_q + 32'd1;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_proc.sv
// ----------------------------------------------------------------------------
// tb_multicycle_proc
// Directed programs run against a byte-addressed memory model with a
// programmable number of wait cycles. Expected memory transactions and
// retirements (next PC plus cycles since the previous retirement) are queued
// when each program is written; a monitor pops and compares them.
// ----------------------------------------------------------------------------
module tb_multicycle_proc;
   localparam int DW = 64;
   localparam int AW = 64;
   localparam logic [10:0] OP_LDUR = 11'h7C2, OP_STUR = 11'h7C0, OP_ADD = 11'h458;
   localparam logic [10:0] OP_SUB  = 11'h658, OP_AND  = 11'h450, OP_ORR = 11'h550;

   logic          CLK = 1'b0;
   logic          Reset = 1'b1;
   logic [AW-1:0] startPC = '0;
   logic [AW-1:0] currentPC;
   logic          retire, trap;
`ifdef MULTICYCLE_PERF_CNT_EN
   logic [31:0]   cycle_cnt, instr_cnt;
   int            base_cyc = 0;
`endif

   multicycle_proc_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   multicycle_proc #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .startPC   (startPC),
      .currentPC (currentPC),
      .mem       (bus),
      .retire    (retire),
      .trap      (trap)
`ifdef MULTICYCLE_PERF_CNT_EN
      ,
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct { logic we; logic [63:0] addr; logic [63:0] data; } txn_t;
   typedef struct { logic [63:0] npc; int lat; } ret_t;
   txn_t txn_q[$];
   ret_t ret_q[$];

   int n_chk = 0, n_pass = 0;
   int cyc = 0, last_ret = 0;
   int unsigned waits = 0, wcnt = 0;
   logic [7:0] mem_b [0:4095];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", nm, act, exp);
   endtask

   function automatic logic [63:0] rd64(input logic [63:0] a);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = mem_b[(int'(a[11:0]) + i) % 4096];
      return r;
   endfunction

   task automatic put64(input int a, input logic [63:0] d);
      for (int i = 0; i < 8; i++) mem_b[(a + i) % 4096] = d[8*i +: 8];
   endtask

   task automatic put32(input int a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) mem_b[(a + i) % 4096] = w[8*i +: 8];
   endtask

   function automatic logic [31:0] enc_d(input logic [10:0] op, input int imm, input int rn, input int rt);
      logic [8:0] i9;
      i9 = imm[8:0];
      return {op, i9, 2'b00, rn[4:0], rt[4:0]};
   endfunction

   function automatic logic [31:0] enc_r(input logic [10:0] op, input int rm, input int rn, input int rd);
      return {op, rm[4:0], 6'b000000, rn[4:0], rd[4:0]};
   endfunction

   function automatic logic [31:0] enc_cbz(input int imm, input int rt);
      logic [18:0] i19;
      i19 = imm[18:0];
      return {8'hB4, i19, rt[4:0]};
   endfunction

   function automatic logic [31:0] enc_b(input int imm);
      logic [25:0] i26;
      i26 = imm[25:0];
      return {6'h05, i26};
   endfunction

   // Place an instruction and expect its fetch.
   task automatic prog(input int pc, input logic [31:0] w);
      put32(pc, w);
      txn_q.push_back('{1'b0, 64'(pc), 64'd0});
   endtask
   task automatic e_rd(input int a);
      txn_q.push_back('{1'b0, 64'(a), 64'd0});
   endtask
   task automatic e_wr(input int a, input logic [63:0] d);
      txn_q.push_back('{1'b1, 64'(a), d});
   endtask
   task automatic e_ret(input int npc, input int lat);
      ret_q.push_back('{64'(npc), lat});
   endtask

   // Memory model: completes the acked transfer on the edge, then presents
   // ack/rdata for the new cycle shortly after it.
   always @(posedge CLK) begin
      if (Reset) wcnt = 0;
      else if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b1) begin
         if (bus.mem_we)
            for (int i = 0; i < 8; i++) mem_b[(int'(bus.mem_addr[11:0]) + i) % 4096] = bus.mem_wdata[8*i +: 8];
         wcnt = 0;
      end else if (bus.mem_req === 1'b1) wcnt++;
      #1;
      bus.mem_ack   = (bus.mem_req === 1'b1) && (wcnt == waits);
      bus.mem_rdata = rd64(bus.mem_addr);
   end

   always @(posedge CLK) if (!Reset) cyc++;

   // Monitor / scoreboard
   ret_t r;
   txn_t t;
   always @(negedge CLK) begin
      if (Reset) last_ret = cyc;
      else begin
         if (retire === 1'b1) begin
            if (ret_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_retire: pc %h, none queued", currentPC);
            end else begin
               r = ret_q.pop_front();
               chk("retire_next_pc", currentPC, r.npc);
               chk("retire_latency", 64'(cyc - last_ret), 64'(r.lat));
               last_ret = cyc;
            end
         end
         if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b1) begin
            if (txn_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_txn: addr %h we %b, none queued", bus.mem_addr, bus.mem_we);
            end else begin
               t = txn_q.pop_front();
               chk("txn_we", 64'(bus.mem_we), 64'(t.we));
               chk("txn_addr", bus.mem_addr, t.addr);
               if (t.we) chk("txn_wdata", bus.mem_wdata, t.data);
            end
         end
      end
   end

   task automatic do_reset(input int pc, input int unsigned w);
      Reset   = 1'b1;
      startPC = 64'(pc);
      waits   = w;
      repeat (2) @(negedge CLK);
      chk("rst_req", 64'(bus.mem_req), 64'd0);
      chk("rst_retire", 64'(retire), 64'd0);
      chk("rst_trap", 64'(trap), 64'd0);
      chk("rst_pc", currentPC, 64'(pc));
      Reset = 1'b0;
`ifdef MULTICYCLE_PERF_CNT_EN
      base_cyc = cyc;
`endif
      @(negedge CLK);
      chk("first_req", 64'(bus.mem_req), 64'd1);
      chk("first_addr", bus.mem_addr, 64'(pc));
   endtask

   task automatic wait_trap(input int pc, input int n_instr);
      int k = 0;
      while (trap !== 1'b1 && k < 3000) begin
         @(negedge CLK);
         k++;
      end
      chk("trap_set", 64'(trap), 64'd1);
      chk("retires_left", 64'(ret_q.size()), 64'd0);
      chk("txns_left", 64'(txn_q.size()), 64'd0);
`ifdef MULTICYCLE_PERF_CNT_EN
      chk("instr_cnt", 64'(instr_cnt), 64'(n_instr));
      chk("cycle_cnt", 64'(cycle_cnt), 64'(cyc - base_cyc));
`endif
      repeat (20) begin
         @(negedge CLK);
         chk("halt_req", 64'(bus.mem_req), 64'd0);
         chk("halt_pc", currentPC, 64'(pc));
         chk("halt_trap", 64'(trap), 64'd1);
      end
      if (n_instr < 0) $display("n_instr negative");
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem_b[i] = 8'h00;
      put64(64, 5);  put64(72, 7);  put64(80, 1);  put64(88, 12);

      // Program 1: ALU ops and stores, zero-wait memory
      prog(32'h100, enc_d(OP_LDUR, 64, 0, 1));  e_rd(64);  e_ret(32'h104, 6);
      prog(32'h104, enc_d(OP_LDUR, 72, 0, 2));  e_rd(72);  e_ret(32'h108, 5);
      prog(32'h108, enc_d(OP_LDUR, 88, 0, 9));  e_rd(88);  e_ret(32'h10C, 5);
      prog(32'h10C, enc_r(OP_ADD, 2, 1, 3));    e_ret(32'h110, 4);
      prog(32'h110, enc_r(OP_SUB, 2, 1, 5));    e_ret(32'h114, 4);
      prog(32'h114, enc_r(OP_AND, 9, 1, 6));    e_ret(32'h118, 4);
      prog(32'h118, enc_r(OP_ORR, 9, 1, 7));    e_ret(32'h11C, 4);
      prog(32'h11C, enc_d(OP_STUR, 8, 0, 3));   e_wr(8, 64'd12);                  e_ret(32'h120, 4);
      prog(32'h120, enc_d(OP_STUR, 16, 0, 5));  e_wr(16, 64'hFFFF_FFFF_FFFF_FFFE); e_ret(32'h124, 4);
      prog(32'h124, enc_d(OP_STUR, -5, 1, 6));  e_wr(0, 64'd4);                   e_ret(32'h128, 4);
      prog(32'h128, enc_d(OP_STUR, 32, 0, 7));  e_wr(32, 64'd13);                 e_ret(32'h12C, 4);
      prog(32'h12C, enc_d(OP_STUR, 24, 0, 31)); e_wr(24, 64'd0);                  e_ret(32'h130, 4);
      prog(32'h130, 32'hFFFF_FFFF);
      do_reset(32'h100, 0);
      wait_trap(32'h130, 12);

      // Program 2: store/load round trip, 3 wait cycles on every access
      put64(8, 0);
      prog(32'h200, enc_d(OP_LDUR, 64, 0, 1));  e_rd(64); e_ret(32'h204, 12);
      prog(32'h204, enc_d(OP_LDUR, 72, 0, 2));  e_rd(72); e_ret(32'h208, 11);
      prog(32'h208, enc_r(OP_ADD, 2, 1, 3));    e_ret(32'h20C, 7);
      prog(32'h20C, enc_d(OP_STUR, 8, 0, 3));   e_wr(8, 64'd12);  e_ret(32'h210, 10);
      prog(32'h210, enc_d(OP_LDUR, 8, 0, 4));   e_rd(8);          e_ret(32'h214, 11);
      prog(32'h214, enc_d(OP_STUR, 40, 0, 4));  e_wr(40, 64'd12); e_ret(32'h218, 10);
      prog(32'h218, 32'hFFFF_FFFF);
      do_reset(32'h200, 3);
      wait_trap(32'h218, 6);

      // Reset while a fetch is still waiting: the request is abandoned
      do_reset(32'h100, 5);

      // Program 3: branches, 1 wait cycle on every access
      prog(32'h100, enc_b(8));                  e_ret(32'h120, 5);
      prog(32'h120, enc_cbz(-2, 5));            e_ret(32'h118, 4);
      prog(32'h118, enc_d(OP_LDUR, 80, 0, 5));  e_rd(80); e_ret(32'h11C, 7);
      prog(32'h11C, enc_b(1));                  e_ret(32'h120, 4);
      prog(32'h120, enc_cbz(-2, 5));            e_ret(32'h124, 4);
      prog(32'h124, enc_b(2));                  e_ret(32'h12C, 4);
      prog(32'h12C, enc_b(32'h3FF_FFFF));       e_ret(32'h128, 4);
      prog(32'h128, 32'hFFFF_FFFF);
      do_reset(32'h100, 1);
      wait_trap(32'h128, 7);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/multicycle_proc.md
Name: multicycle_proc

Overview:
- Parametrised multi-cycle LEGv8-subset core; next generation of the team's single-cycle processor.
- Same instruction subset, executed over 3–5 cycles by a control FSM.
- Shares one external unified memory port, with a req/ack handshake, for instruction fetch and data access.
- Contains the register file, ALU and immediate extension internally. Sits between the testbench/system top and a wait-state-capable memory model.

Parameters:
DATA_W, 64, register/ALU/data width (>= 32)
ADDR_W, 64, PC and memory address width (>= 16)

Ports:
CLK  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
startPC  input  ADDR_W  PC loaded while Reset is high
currentPC  output  ADDR_W  address of instruction in progress
mem_req  output  1  memory request, held until ack
mem_we  output  1  1 = write (STUR), 0 = read
mem_addr  output  ADDR_W  byte address
mem_wdata  output  DATA_W  store data
mem_rdata  input  DATA_W  read data; instruction on [31:0]
mem_ack  input  1  request complete this cycle
retire  output  1  one-cycle pulse when an instruction completes
trap  output  1  sticky; illegal opcode encountered

Behaviour:
- Reset (sampled on CLK rising edge while Reset=1):
  - currentPC=startPC, state=FETCH.
  - mem_req=0, mem_we=0, retire=0, trap=0.
  - All 32 registers cleared to 0.
  - Reset mid-transaction abandons it; mem_req drops the cycle after reset is sampled.
- Decode:
  - Opcodes: LDUR 11'h7C2, STUR 11'h7C0, ADD 11'h458, SUB 11'h658, AND 11'h450, ORR 11'h550 (bits 31:21); CBZ 8'hB4 (31:24); B 6'h05 (31:26).
  - X31 reads as 0; writes to X31 discarded.
- Immediates (sign-extended to ADDR_W/DATA_W):
  - D-type imm9 = [20:12].
  - CBZ imm19 = [23:5], shifted left 2.
  - B imm26 = [25:0], shifted left 2.
- Arithmetic:
  - Modulo 2^DATA_W; no flags except zero test.
  - PC arithmetic modulo 2^ADDR_W; wrap-around permitted.
- FSM states, transitions and outputs:
  - FETCH: mem_req=1, mem_we=0, mem_addr=currentPC.
    - On mem_ack: IR <= mem_rdata[31:0], go to DECODE.
    - Otherwise stay; outputs stable.
  - DECODE: read Rn and Rm/Rt into A/B latches.
    - Rt is used for STUR/CBZ.
    - Illegal opcode: trap=1, go to HALT.
  - EXEC:
    - R-type: ALU result latched, go to WB.
    - LDUR/STUR: address = A + imm9, go to MEM.
    - CBZ: PC <= (B==0) ? PC+imm19 : PC+4; retire; go to FETCH.
    - B: PC <= PC+imm26; retire; go to FETCH.
  - MEM: mem_req=1, mem_addr=address, mem_we=(STUR), mem_wdata=B.
    - On mem_ack, STUR: PC+4, retire, go to FETCH.
    - On mem_ack, LDUR: latch mem_rdata, go to WB.
  - WB: Rd <= result (or load data); PC <= PC+4; retire; go to FETCH.
  - HALT: terminal. No requests, PC frozen, trap held; exit only via Reset.
- Handshake:
  - mem_ack is sampled only while mem_req=1; ack with req=0 is ignored.
  - Ack in the same cycle as the first req cycle is legal (zero wait).
  - mem_addr, mem_we and mem_wdata are stable while req=1 and ack=0.
- Latency (zero-wait memory): B/CBZ 3 cycles, ADD/SUB/AND/ORR 4, STUR 4, LDUR 5. Each memory wait cycle adds 1.
- Register write occurs only in WB. A read of a register written by the previous instruction sees the new value, since DECODE always follows WB.

Optional Feature:
MULTICYCLE_PERF_CNT_EN
- Defined:
  - Extra outputs cycle_cnt[31:0] and instr_cnt[31:0], both cleared by Reset.
  - cycle_cnt increments every non-reset cycle, including HALT.
  - instr_cnt increments on each retire.
  - Both wrap 0xFFFFFFFF->0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset with startPC=0x100, zero-wait mem -> first mem_addr=0x100, mem_req=1 in the cycle after Reset falls; trap=0, retire=0.
- ADD X3,X1,X2 with X1=5, X2=7 (preloaded via LDUR), zero-wait -> X3=12 after 4 cycles; retire single pulse; currentPC advances by 4.
- STUR X3,[X0,#8] then LDUR X4,[X0,#8], with 3 wait cycles on every ack -> write to addr 8 with data 12; X4=12. Per-instruction latency: STUR 4+6=10 cycles, LDUR 5+6=11 cycles.
- CBZ X5,#-2 with X5=0 at PC 0x120 -> next fetch 0x118. With X5=1 -> next fetch 0x124. B #0x3FFFFFF (imm26=-1) -> PC-4.
- Fetch word 0xFFFFFFFF -> trap=1 after DECODE. mem_req stays 0 and PC stays frozen for 20 cycles. Reset clears trap and refetches startPC.
- With MULTICYCLE_PERF_CNT_EN: 10-instruction mix -> instr_cnt=10, and cycle_cnt equals the sum of the per-instruction latencies plus wait cycles.
